adder_vec_writer: RTL and testbench

Synthesizable stimulus writer for the `adder_sub` verification flow. It generates operand pairs and the expected 9-bit result, then emits each vector as three 17-bit words on a valid/ready stream: A, B, expected. This is the same word order and width as the `adder.txt` vector memory read by the checker bench. The block sits between a run controller (start/done) and either a vector-capture memory or the checker's vector input, and produces a reproducible vector set on every run.

---
 rtl/adder_vec_pkg.sv | 52 +++++
 rtl/adder_vec_writer_lfsr8.sv | 44 ++++
 rtl/adder_vec_writer.sv | 210 +++++++++++++++++++++
 tb/tb_adder_vec_writer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_vec_pkg.sv
// -----------------------------------------------------------------------------
// adder_vec_pkg
// Shared types and constants for the adder_sub stimulus writer:
//   - FSM state encoding
//   - output word-select codes
//   - default stream word width and operand width
//   - 8-bit Fibonacci LFSR tap mask and step function
//   - expected-result arithmetic (add / subtract, 9-bit result)
// -----------------------------------------------------------------------------
package adder_vec_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int WORD_W_DEF = 17;

    // Taps b7, b5, b4, b3 of the shift-left Fibonacci LFSR.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_A   = 3'd1,
        ST_SEND_B   = 3'd2,
        ST_SEND_EXP = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2,
        SEL_EXP  = 2'd3
    } word_sel_e;

    // One LFSR step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

    // Expected adder_sub result. In subtract mode bit 8 is the carry out of
    // A + ~B + 1, i.e. 1 when no borrow occurred.
    function automatic logic [8:0] exp_calc(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic       sub);
        logic [8:0] res;
        if (sub) begin
            res = {1'b0, a} + {1'b0, ~b} + 9'd1;
        end else begin
            res = {1'b0, a} + {1'b0, b};
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_vec_writer_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR (shift left, taps b7^b5^b4^b3) used as the B operand
// source. Load has priority over step; otherwise the value holds.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset, q <= RESET_VAL
//   load     in   q <= seed
//   seed     in   [7:0] value loaded on load
//   step     in   advance one LFSR step
//   q        out  [7:0] current LFSR value (registered)
// A non-zero seed/RESET_VAL keeps the sequence away from the all-zero lock-up.
// -----------------------------------------------------------------------------
module lfsr8
    import adder_vec_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] r_q;

    // LFSR state register: load, step or hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= RESET_VAL;
        end else if (load) begin
            r_q <= seed;
        end else if (step) begin
            r_q <= lfsr8_next(r_q);
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/adder_vec_writer.sv
// -----------------------------------------------------------------------------
// adder_vec_writer
// Generates NUM_VECS adder_sub test vectors per run and streams each one as
// three zero-extended WORD_W words on a valid/ready interface: A, B, EXP.
// A counts up from 0 (wrapping), B comes from an 8-bit LFSR seeded with SEED,
// EXP is the 9-bit add or subtract result for the mode latched at start.
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   single-cycle run request, ignored while busy
//   sub_mode    in   0 = add, 1 = subtract; sampled on an accepted start
//   word_out    out  [WORD_W-1:0] current stream word
//   word_valid  out  word_out is valid
//   word_ready  in   sink accepts the word
//   busy        out  a run is in progress
//   done        out  run completed; held until next accepted start or reset
//   vec_count   out  vectors fully transferred in the current run
// All outputs are registers or decodes of registered state only; nothing
// depends combinationally on word_ready or start.
// -----------------------------------------------------------------------------
module adder_vec_writer
    import adder_vec_pkg::*;
#(
    parameter int         DATA_W   = DATA_W_DEF,
    parameter int         WORD_W   = WORD_W_DEF,
    parameter int         NUM_VECS = 324,
    parameter logic [7:0] SEED     = 8'hA5,
    localparam int        CNT_W    = $clog2(NUM_VECS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              sub_mode,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  vec_count
);

    state_e              r_state;
    state_e              w_state_next;
    logic [DATA_W-1:0]   r_a;
    logic                r_sub;
    logic [CNT_W-1:0]    r_vec_count;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W:0]     w_exp;
    word_sel_e           w_sel;
    logic                w_valid;
    logic                w_busy;
    logic                w_done;
    logic                w_xfer;
    logic                w_accept;
    logic                w_last;
    logic                w_exp_xfer;
    logic                w_lfsr_step;
    logic [WORD_W-1:0]   w_word;

    assign w_xfer      = w_valid & word_ready;
    assign w_accept    = start & ~w_busy;
    assign w_last      = (r_vec_count == CNT_W'(NUM_VECS - 1));
    assign w_exp_xfer  = w_xfer & (r_state == ST_SEND_EXP);
    assign w_lfsr_step = w_exp_xfer & ~w_last;
    assign w_exp       = exp_calc(r_a, w_b, r_sub);

    // B operand source; reloaded with SEED on every accepted start.
    lfsr8 #(
        .RESET_VAL (SEED)
    ) u_lfsr_b (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_accept),
        .seed    (SEED),
        .step    (w_lfsr_step),
        .q       (w_b)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; each SEND state advances only on a transfer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_SEND_A;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_SEND_A: begin
                if (w_xfer) begin
                    w_state_next = ST_SEND_B;
                end else begin
                    w_state_next = ST_SEND_A;
                end
            end
            ST_SEND_B: begin
                if (w_xfer) begin
                    w_state_next = ST_SEND_EXP;
                end else begin
                    w_state_next = ST_SEND_B;
                end
            end
            ST_SEND_EXP: begin
                if (w_xfer && w_last) begin
                    w_state_next = ST_DONE;
                end else if (w_xfer) begin
                    w_state_next = ST_SEND_A;
                end else begin
                    w_state_next = ST_SEND_EXP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: stream control and word select from state only.
    always_comb begin
        w_sel   = SEL_ZERO;
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_SEND_A: begin
                w_sel   = SEL_A;
                w_valid = 1'b1;
                w_busy  = 1'b1;
            end
            ST_SEND_B: begin
                w_sel   = SEL_B;
                w_valid = 1'b1;
                w_busy  = 1'b1;
            end
            ST_SEND_EXP: begin
                w_sel   = SEL_EXP;
                w_valid = 1'b1;
                w_busy  = 1'b1;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            ST_IDLE: begin
                w_sel = SEL_ZERO;
            end
            default: begin
                w_sel = SEL_ZERO;
            end
        endcase
    end

    // Operand A counter and latched mode; A wraps naturally at DATA_W bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_a   <= '0;
            r_sub <= sub_mode;
        end else if (w_lfsr_step) begin
            r_a   <= r_a + DATA_W'(1);
            r_sub <= r_sub;
        end else begin
            r_a   <= r_a;
            r_sub <= r_sub;
        end
    end

    // Completed-vector counter, bumped on each EXP transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vec_count <= '0;
        end else if (w_accept) begin
            r_vec_count <= '0;
        end else if (w_exp_xfer) begin
            r_vec_count <= r_vec_count + CNT_W'(1);
        end else begin
            r_vec_count <= r_vec_count;
        end
    end

    // Word mux; idle and done present zero.
    always_comb begin
        w_word = '0;
        case (w_sel)
            SEL_A:    w_word = {{(WORD_W - DATA_W){1'b0}}, r_a};
            SEL_B:    w_word = {{(WORD_W - DATA_W){1'b0}}, w_b};
            SEL_EXP:  w_word = {{(WORD_W - DATA_W - 1){1'b0}}, w_exp};
            SEL_ZERO: w_word = '0;
            default:  w_word = '0;
        endcase
    end

    assign word_out   = w_word;
    assign word_valid = w_valid;
    assign busy       = w_busy;
    assign done       = w_done;
    assign vec_count  = r_vec_count;

endmodule

// File: tb/tb_adder_vec_writer.sv
module tb_adder_vec_writer;

    localparam int NV     = 324;
    localparam int NWORDS = 3 * NV;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        sub_mode;
    logic [16:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic        done;
    logic [8:0]  vec_count;

    int checks;
    int errors;

    logic [16:0] exp_words [NWORDS];
    logic [16:0] cap       [NWORDS];

    adder_vec_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .sub_mode   (sub_mode),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .done       (done),
        .vec_count  (vec_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic sub);
        start    = 1'b1;
        sub_mode = sub;
        step();
        start    = 1'b0;
        sub_mode = 1'b0;
    endtask

    // Independent model: A counts, B from LFSR taps b7^b5^b4^b3, add mode.
    task automatic build_model();
        logic [7:0] ma;
        logic [7:0] mb;
        logic [8:0] me;
        ma = 8'h00;
        mb = 8'hA5;
        for (int v = 0; v < NV; v++) begin
            me = {1'b0, ma} + {1'b0, mb};
            exp_words[3*v]     = {9'd0, ma};
            exp_words[3*v + 1] = {9'd0, mb};
            exp_words[3*v + 2] = {8'd0, me};
            ma = ma + 8'd1;
            mb = {mb[6:0], mb[7] ^ mb[5] ^ mb[4] ^ mb[3]};
        end
    endtask

    // Stream a run to completion, checking every transferred word.
    task automatic run_stream(input bit rand_ready, input bit capture,
                              output int n_xfer, output int n_cyc);
        n_xfer = 0;
        n_cyc  = 0;
        while (busy && n_cyc < 6000) begin
            word_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (word_valid && word_ready) begin
                if (n_xfer < NWORDS) begin
                    chk("stream_word", 32'(word_out), 32'(exp_words[n_xfer]));
                    if (capture) cap[n_xfer] = word_out;
                end
                n_xfer++;
            end
            step();
            n_cyc++;
        end
        word_ready = 1'b1;
        chk("run_terminated", 32'(busy), 32'd0);
    endtask

    initial begin
        int nx;
        int nc;
        int zeros;
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        sub_mode   = 1'b0;
        word_ready = 1'b0;
        build_model();

        // Reset state
        step();
        step();
        chk("rst_word_out", 32'(word_out), 32'd0);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vec_count", 32'(vec_count), 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_valid", 32'(word_valid), 32'd0);

        // First vectors, add mode
        word_ready = 1'b1;
        do_start(1'b0);
        chk("add_valid", 32'(word_valid), 32'd1);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_w0", 32'(word_out), 32'h00000);
        step();
        chk("add_w1", 32'(word_out), 32'h000A5);
        step();
        chk("add_w2", 32'(word_out), 32'h000A5);
        step();
        chk("add_w3", 32'(word_out), 32'h00001);
        chk("add_cnt1", 32'(vec_count), 32'd1);
        step();
        chk("add_w4", 32'(word_out), 32'h0004A);
        step();
        chk("add_w5", 32'(word_out), 32'h0004B);

        // Asynchronous reset mid-run in SEND_EXP
        reset_n = 1'b0;
        #1;
        chk("mid_rst_word", 32'(word_out), 32'd0);
        chk("mid_rst_valid", 32'(word_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(vec_count), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        #2;
        reset_n = 1'b1;
        step();

        // Subtract mode, backpressure in SEND_B, start ignored mid-run
        do_start(1'b1);
        chk("sub_w0", 32'(word_out), 32'h00000);
        step();
        chk("sub_w1", 32'(word_out), 32'h000A5);
        word_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            step();
            chk("bp_word", 32'(word_out), 32'h000A5);
            chk("bp_valid", 32'(word_valid), 32'd1);
        end
        start      = 1'b0;
        word_ready = 1'b1;
        step();
        chk("sub_w2", 32'(word_out), 32'h0005B);
        step();
        chk("sub_w3", 32'(word_out), 32'h00001);
        step();
        chk("sub_w4", 32'(word_out), 32'h0004A);
        step();
        chk("sub_w5", 32'(word_out), 32'h000B7);

        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();

        // Full run with defaults, ready held high
        do_start(1'b0);
        run_stream(1'b0, 1'b1, nx, nc);
        chk("full_xfers", 32'(nx), 32'(NWORDS));
        chk("full_cycles", 32'(nc), 32'(NWORDS));
        chk("full_done", 32'(done), 32'd1);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_valid", 32'(word_valid), 32'd0);
        chk("full_cnt", 32'(vec_count), 32'(NV));
        chk("wrap_a256", 32'(cap[3*256]), 32'd0);
        zeros = 0;
        for (int v = 0; v < NV; v++) begin
            if (cap[3*v + 1] == 17'd0) zeros++;
        end
        chk("b_nonzero", 32'(zeros), 32'd0);
        step();
        chk("done_held", 32'(done), 32'd1);

        // Restart from DONE with random backpressure; identical stream
        do_start(1'b0);
        chk("restart_done_clr", 32'(done), 32'd0);
        chk("restart_cnt_clr", 32'(vec_count), 32'd0);
        run_stream(1'b1, 1'b0, nx, nc);
        chk("rerun_xfers", 32'(nx), 32'(NWORDS));
        chk("rerun_done", 32'(done), 32'd1);
        chk("rerun_cnt", 32'(vec_count), 32'(NV));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
